// File: rtl/arbitro_balance.sv
// Shared-balance arbiter: four terminals compete round-robin for deposits and withdrawals
// against one 64-bit account; each transaction takes IDLE -> EXEC -> RESP, one cycle each.
module arbitro_balance #(
  parameter logic [63:0] BALANCE_INICIAL = 64'd10000
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [3:0]     REQ,
  input  logic [3:0]     TIPO,
  input  logic [127:0]   MONTO_BUS,
  output logic [3:0]     GNT,
  output logic [3:0]     DONE,
  output logic [63:0]    BALANCE,
  output logic           BALANCE_ACT,
  output logic           FONDOS_INSUF,
  output logic           DESBORDE,
  output logic           BUSY
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      r_state, w_state_next;
  logic [1:0]  r_last, r_winner;
  logic [1:0]  w_winner, w_idx;
  logic        r_tipo;
  logic [31:0] r_monto;
  logic [3:0]  r_gnt, r_done;
  logic [63:0] r_balance;
  logic        r_act, r_insuf, r_desborde;
  logic [64:0] w_sum;
  logic        w_retiro_ok;

  // Scan from the farthest offset down so the nearest requester after LAST wins.
  always_comb begin
    w_winner = r_last + 2'd1;
    w_idx    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_last + 2'd1 + 2'(i);
      if (REQ[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_sum       = {1'b0, r_balance} + {33'd0, r_monto};
  assign w_retiro_ok = ({32'd0, r_monto} <= r_balance);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  w_state_next = (|REQ) ? StExec : StIdle;
      StExec:  w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    BUSY = (r_state != StIdle);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_last     <= 2'd3;
      r_winner   <= 2'd0;
      r_tipo     <= 1'b0;
      r_monto    <= 32'd0;
      r_gnt      <= 4'd0;
      r_done     <= 4'd0;
      r_balance  <= BALANCE_INICIAL;
      r_act      <= 1'b0;
      r_insuf    <= 1'b0;
      r_desborde <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|REQ) begin
            r_winner <= w_winner;
            r_gnt    <= 4'b0001 << w_winner;
            r_tipo   <= TIPO[w_winner];
            r_monto  <= MONTO_BUS[{w_winner, 5'd0} +: 32];
          end
        end
        StExec: begin
          r_done <= 4'b0001 << r_winner;
          if (r_tipo) begin
            if (!w_sum[64]) begin
              r_balance <= w_sum[63:0];
              r_act     <= 1'b1;
            end else begin
              r_desborde <= 1'b1;
            end
          end else if (w_retiro_ok) begin
            r_balance <= r_balance - {32'd0, r_monto};
            r_act     <= 1'b1;
          end else begin
            r_insuf <= 1'b1;
          end
        end
        StResp: begin
          r_gnt      <= 4'd0;
          r_done     <= 4'd0;
          r_act      <= 1'b0;
          r_insuf    <= 1'b0;
          r_desborde <= 1'b0;
          r_last     <= r_winner;
        end
        default: begin
          r_gnt <= 4'd0;
        end
      endcase
    end
  end

  assign GNT          = r_gnt;
  assign DONE         = r_done;
  assign BALANCE      = r_balance;
  assign BALANCE_ACT  = r_act;
  assign FONDOS_INSUF = r_insuf;
  assign DESBORDE     = r_desborde;

endmodule

// File: tb/tb_arbitro_balance.sv
// Scoreboard bench for arbitro_balance: expected completions are queued when requests are
// driven and compared when DONE appears; a second instance covers the overflow boundary.
module tb_arbitro_balance;

  localparam logic [63:0] Init  = 64'd10000;
  localparam logic [63:0] Init2 = 64'hFFFF_FFFF_FFFF_FFFB;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [3:0]   REQ = 4'd0, TIPO = 4'd0;
  logic [127:0] MONTO_BUS = '0;
  logic [3:0]   GNT, DONE;
  logic [63:0]  BALANCE;
  logic         BALANCE_ACT, FONDOS_INSUF, DESBORDE, BUSY;

  logic [3:0]   req2 = 4'd0, tipo2 = 4'd0;
  logic [127:0] monto2 = '0;
  logic [3:0]   gnt2, done2;
  logic [63:0]  balance2;
  logic         act2, insuf2, desborde2, busy2;

  arbitro_balance #(.BALANCE_INICIAL(Init)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .TIPO(TIPO), .MONTO_BUS(MONTO_BUS),
    .GNT(GNT), .DONE(DONE), .BALANCE(BALANCE), .BALANCE_ACT(BALANCE_ACT),
    .FONDOS_INSUF(FONDOS_INSUF), .DESBORDE(DESBORDE), .BUSY(BUSY)
  );

  arbitro_balance #(.BALANCE_INICIAL(Init2)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(req2), .TIPO(tipo2), .MONTO_BUS(monto2),
    .GNT(gnt2), .DONE(done2), .BALANCE(balance2), .BALANCE_ACT(act2),
    .FONDOS_INSUF(insuf2), .DESBORDE(desborde2), .BUSY(busy2)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  done;
    logic [63:0] bal;
    logic [2:0]  flags;  // {BALANCE_ACT, FONDOS_INSUF, DESBORDE}
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_err = 0;
  int          cyc = 0;
  logic [63:0] m_bal, m_bal2;
  bit          rr_mode = 0;
  int          rr_seen = 0, last_done_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops the scoreboard on DONE and checks pulses end after one cycle.
  initial begin
    exp_t e;
    bit   prev_done = 0;
    forever begin
      @(negedge CLK);
      if (prev_done) check("pulse_clear", {GNT, DONE, BALANCE_ACT, FONDOS_INSUF, DESBORDE}, 0);
      prev_done = (DONE !== 4'd0);
      if (prev_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", DONE, 0);
        end else begin
          e = sb.pop_front();
          check("done", DONE, e.done);
          check("gnt_at_done", GNT, e.done);
          check("balance", BALANCE, e.bal);
          check("flags", {BALANCE_ACT, FONDOS_INSUF, DESBORDE}, e.flags);
          if (rr_mode) begin
            if (rr_seen > 0) check("rr_spacing", cyc - last_done_cyc, 3);
            rr_seen++;
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic run_txn(input int t, input bit tipo, input logic [31:0] monto,
                         input bit scramble);
    exp_t        e;
    logic [64:0] sum;
    int          k;
    @(negedge CLK);
    REQ = 4'b0001 << t;
    TIPO[t] = tipo;
    MONTO_BUS[t*32 +: 32] = monto;
    e.done  = 4'b0001 << t;
    e.flags = 3'b000;
    if (tipo) begin
      sum = {1'b0, m_bal} + {33'd0, monto};
      if (sum[64]) e.flags = 3'b001;
      else begin
        m_bal = sum[63:0];
        e.flags = 3'b100;
      end
    end else if ({32'd0, monto} <= m_bal) begin
      m_bal = m_bal - {32'd0, monto};
      e.flags = 3'b100;
    end else begin
      e.flags = 3'b010;
    end
    e.bal = m_bal;
    sb.push_back(e);
    @(posedge CLK); #1;
    check("gnt_latency", GNT, e.done);
    check("busy", BUSY, 1);
    if (scramble) begin
      REQ = 4'd0;
      TIPO = ~TIPO;
      MONTO_BUS = ~MONTO_BUS;
    end
    for (k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (DONE !== 4'd0) break;
    end
    if (k == 10) check("done_timeout", 0, 1);
    REQ = 4'd0;
    @(posedge CLK); #1;
    check("idle_busy", BUSY, 0);
  endtask

  task automatic run2(input logic [31:0] monto, input bit ovf);
    int k;
    @(negedge CLK);
    req2 = 4'b0001;
    tipo2 = 4'b0001;
    monto2[31:0] = monto;
    for (k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (done2 !== 4'd0) break;
    end
    if (k == 10) check("done2_timeout", 0, 1);
    if (!ovf) m_bal2 = m_bal2 + {32'd0, monto};
    check("done2", done2, 4'b0001);
    check("desborde2", desborde2, ovf);
    check("act2", act2, !ovf);
    check("balance2", balance2, m_bal2);
    req2 = 4'd0;
    @(posedge CLK); #1;
  endtask

  initial begin
    exp_t e;
    int   k;
    m_bal  = Init;
    m_bal2 = Init2;
    #12;
    check("rst_balance", BALANCE, Init);
    check("rst_outs", {GNT, DONE, BALANCE_ACT, FONDOS_INSUF, DESBORDE, BUSY}, 0);
    check("rst_balance2", balance2, Init2);
    @(negedge CLK) RESET_N = 1'b1;

    run_txn(0, 1'b1, 32'h0000_AAA0, 1'b0);
    run_txn(1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_txn(2, 1'b0, m_bal[31:0], 1'b0);
    run_txn(3, 1'b0, 32'd1, 1'b0);
    run_txn(0, 1'b1, 32'd0, 1'b0);
    run_txn(0, 1'b0, 32'd0, 1'b0);
    run_txn(1, 1'b1, 32'd5000, 1'b1);
    run_txn(2, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Fresh reset so the round-robin pointer starts from terminal 0.
    @(negedge CLK) RESET_N = 1'b0;
    m_bal = Init;
    #1 check("rst2_balance", BALANCE, Init);
    @(negedge CLK) RESET_N = 1'b1;
    TIPO = 4'hF;
    MONTO_BUS = {4{32'd1}};
    for (int i = 0; i < 5; i++) begin
      m_bal = m_bal + 64'd1;
      e.done  = 4'b0001 << (i % 4);
      e.bal   = m_bal;
      e.flags = 3'b100;
      sb.push_back(e);
    end
    rr_mode = 1;
    REQ = 4'hF;
    for (k = 0; k < 40; k++) begin
      @(posedge CLK); #2;
      if (sb.size() == 0) break;
    end
    if (k == 40) check("rr_timeout", sb.size(), 0);
    REQ = 4'd0;
    rr_mode = 0;
    repeat (4) @(posedge CLK);
    #1 check("rr_idle", BUSY, 0);
    check("rr_balance", BALANCE, Init + 64'd5);

    // Abort in EXEC: reset lands one cycle after the grant.
    @(negedge CLK);
    REQ = 4'b0100;
    TIPO[2] = 1'b1;
    MONTO_BUS[95:64] = 32'd100;
    @(posedge CLK); #2;
    check("pre_abort_gnt", GNT, 4'b0100);
    RESET_N = 1'b0;
    m_bal = Init;
    #1;
    check("abort_outs", {GNT, DONE, BALANCE_ACT, FONDOS_INSUF, DESBORDE, BUSY}, 0);
    check("abort_balance", BALANCE, Init);
    @(negedge CLK) REQ = 4'd0;
    @(negedge CLK) RESET_N = 1'b1;
    repeat (6) @(negedge CLK);
    check("abort_after", BALANCE, Init);

    run2(32'd10, 1'b1);
    run2(32'd5, 1'b1);
    run2(32'd4, 1'b0);
    run2(32'd0, 1'b0);
    run2(32'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
